// File: rtl/wisc_ctrl_pkg.sv
// rtl/wisc_ctrl_pkg.sv - state encodings, opcode constants and opcode-class predicates
package wisc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OPC_ADD    = 4'h0;
    localparam logic [3:0] OPC_SUB    = 4'h1;
    localparam logic [3:0] OPC_XOR    = 4'h2;
    localparam logic [3:0] OPC_RED    = 4'h3;
    localparam logic [3:0] OPC_SLL    = 4'h4;
    localparam logic [3:0] OPC_SRA    = 4'h5;
    localparam logic [3:0] OPC_ROR    = 4'h6;
    localparam logic [3:0] OPC_PADDSB = 4'h7;
    localparam logic [3:0] OPC_LW     = 4'h8;
    localparam logic [3:0] OPC_SW     = 4'h9;
    localparam logic [3:0] OPC_LLB    = 4'hA;
    localparam logic [3:0] OPC_LHB    = 4'hB;
    localparam logic [3:0] OPC_B      = 4'hC;
    localparam logic [3:0] OPC_BR     = 4'hD;
    localparam logic [3:0] OPC_PCS    = 4'hE;
    localparam logic [3:0] OPC_HLT    = 4'hF;

    // LW and SW share the 100x prefix.
    function automatic logic f_is_ls(input logic [3:0] opc);
        return opc[3:1] == 3'b100;
    endfunction

    function automatic logic f_is_lw(input logic [3:0] opc);
        return opc == OPC_LW;
    endfunction

    // B and BR share the 110x prefix.
    function automatic logic f_is_br(input logic [3:0] opc);
        return opc[3:1] == 3'b110;
    endfunction

    function automatic logic f_writes_reg(input logic [3:0] opc);
        return !opc[3] || opc == OPC_LW || opc == OPC_LLB ||
               opc == OPC_LHB || opc == OPC_PCS;
    endfunction

    function automatic logic f_uses_imm(input logic [3:0] opc);
        return opc[3] || opc == OPC_SLL || opc == OPC_SRA || opc == OPC_ROR;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_opcode_class.sv
// rtl/multicycle_ctrl_opcode_class.sv - combinational opcode classifier
// Ports:
//   opc        in  4  latched opcode (opc_q of the controller)
//   is_ls      out 1  load or store
//   is_lw      out 1  load
//   is_br      out 1  B or BR
//   writes_reg out 1  instruction retires through a register write
//   uses_imm   out 1  ALU second operand is the immediate
module opcode_class
    import wisc_ctrl_pkg::*;
(
    input  logic [3:0] opc,
    output logic       is_ls,
    output logic       is_lw,
    output logic       is_br,
    output logic       writes_reg,
    output logic       uses_imm
);

    assign is_ls      = f_is_ls(opc);
    assign is_lw      = f_is_lw(opc);
    assign is_br      = f_is_br(opc);
    assign writes_reg = f_writes_reg(opc);
    assign uses_imm   = f_uses_imm(opc);

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle CPU control FSM with retired-instruction counter
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   opcode                      instruction opcode, sampled on the fetch handshake
//   imem_ready, dmem_ready      memory handshakes
//   branch_taken                branch condition for the current B/BR
//   imem_req, dmem_req          memory requests
//   ir_load, pc_write, pc_src   IR capture, PC update and PC source select
//   reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch   datapath controls
//   halted, state, retired      status
module multicycle_ctrl
    import wisc_ctrl_pkg::*;
#(
    parameter int         OPC_W   = 4,
    parameter int         CNT_W   = 16,
    parameter logic [3:0] HLT_OPC = 4'hF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPC_W-1:0] opcode,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             branch_taken,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             ir_load,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             alu_src,
    output logic             branch,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    state_t     cur;
    logic [3:0] opc_q;
    logic       is_ls, is_lw, is_br, writes_reg, uses_imm;
    logic       is_hlt;
    logic       retire;

    // Only the low nibble carries meaning; the upper opcode bits are dropped.
    logic unused_opc_bits;
    assign unused_opc_bits = ^opcode;

    opcode_class u_class (
        .opc        (opc_q),
        .is_ls      (is_ls),
        .is_lw      (is_lw),
        .is_br      (is_br),
        .writes_reg (writes_reg),
        .uses_imm   (uses_imm)
    );

    assign is_hlt = (opc_q == HLT_OPC);
    assign state  = cur;

    // An instruction is complete on every transition back to FETCH, and a
    // halt instruction counts once on entry to HALT.
    always_comb begin
        retire = 1'b0;
        case (cur)
            S_DECODE: retire = is_hlt;
            S_EXEC:   retire = is_br;
            S_MEM:    retire = dmem_ready && !is_lw;
            S_WB:     retire = 1'b1;
            default:  retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur     <= S_FETCH;
            opc_q   <= 4'h0;
            retired <= '0;
        end else begin
            if (retire && retired != {CNT_W{1'b1}}) begin
                retired <= retired + CNT_W'(1);
            end
            case (cur)
                S_FETCH: begin
                    if (imem_ready) begin
                        opc_q <= opcode[3:0];
                        cur   <= S_DECODE;
                    end
                end
                S_DECODE: cur <= is_hlt ? S_HALT : S_EXEC;
                S_EXEC: begin
                    if (is_br) begin
                        cur <= S_FETCH;
                    end else if (is_ls) begin
                        cur <= S_MEM;
                    end else begin
                        cur <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        cur <= is_lw ? S_WB : S_FETCH;
                    end
                end
                S_WB:    cur <= S_FETCH;
                S_HALT:  cur <= S_HALT;
                default: cur <= S_FETCH;
            endcase
        end
    end

    // Outputs follow the state directly so a reset mid-access withdraws
    // requests in the same cycle. The fetch handshake is gated by rst_n so
    // nothing but imem_req is visible while reset is held.
    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        ir_load    = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        branch     = 1'b0;
        halted     = 1'b0;
        case (cur)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ready && rst_n;
                pc_write = imem_ready && rst_n;
            end
            S_EXEC: begin
                alu_src = uses_imm;
                if (is_br) begin
                    branch   = 1'b1;
                    pc_src   = 1'b1;
                    pc_write = branch_taken;
                end
            end
            S_MEM: begin
                dmem_req  = 1'b1;
                mem_read  = is_lw;
                mem_write = is_ls && !is_lw;
            end
            S_WB: begin
                reg_write  = writes_reg;
                mem_to_reg = is_lw;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    localparam int OPC_W = 6;
    localparam int CNT_W = 4;
    localparam int RMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [OPC_W-1:0] opcode = '0;
    logic             imem_ready = 1'b0;
    logic             dmem_ready = 1'b0;
    logic             branch_taken = 1'b0;
    logic             imem_req, dmem_req, ir_load, pc_write, pc_src;
    logic             reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, halted;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    multicycle_ctrl #(.OPC_W(OPC_W), .CNT_W(CNT_W), .HLT_OPC(4'hF)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .imem_ready   (imem_ready),
        .dmem_ready   (dmem_ready),
        .branch_taken (branch_taken),
        .imem_req     (imem_req),
        .dmem_req     (dmem_req),
        .ir_load      (ir_load),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .reg_write    (reg_write),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_to_reg   (mem_to_reg),
        .alu_src      (alu_src),
        .branch       (branch),
        .halted       (halted),
        .state        (state),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    // One expected bus cycle: the inputs to drive and the outputs to see.
    typedef struct {
        logic [2:0]  st;
        logic [11:0] outs;
        logic        ir;
        logic        dr;
        logic        bt;
        logic [3:0]  opc;
        int          ret;
    } cyc_t;

    cyc_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   model_ret = 0;
    int   cyc = 0;

    wire [11:0] obs_outs = {imem_req, dmem_req, ir_load, pc_write, pc_src, reg_write,
                            mem_read, mem_write, mem_to_reg, alu_src, branch, halted};

    function automatic logic [11:0] mk(input bit ireq, dreq, irl, pcw, pcs, rw,
                                       mr, mw, m2r, as, br, h);
        return {ireq, dreq, irl, pcw, pcs, rw, mr, mw, m2r, as, br, h};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    task automatic push(input logic [2:0] st, input logic [11:0] outs,
                        input logic ir, input logic dr, input logic bt, input logic [3:0] opc);
        cyc_t c;
        c.st = st; c.outs = outs; c.ir = ir; c.dr = dr; c.bt = bt; c.opc = opc;
        c.ret = model_ret;
        q.push_back(c);
    endtask

    task automatic bump();
        if (model_ret < RMAX) model_ret++;
    endtask

    // Expected cycle-by-cycle trace of one instruction, from the ISA rules:
    // fetch (with wi wait cycles), decode, then the opcode-specific tail.
    task automatic add_instr(input logic [3:0] opc, input int wi, input int wd, input bit bt);
        bit imm, br, ld, st, h;
        imm = opc[3] || opc == 4'h4 || opc == 4'h5 || opc == 4'h6;
        br  = (opc == 4'hC) || (opc == 4'hD);
        ld  = (opc == 4'h8);
        st  = (opc == 4'h9);
        h   = (opc == 4'hF);
        for (int i = 0; i < wi; i++)
            push(3'd0, mk(1,0,0,0,0,0,0,0,0,0,0,0), 1'b0, rb(), rb(), 4'($urandom));
        push(3'd0, mk(1,0,1,1,0,0,0,0,0,0,0,0), 1'b1, rb(), rb(), opc);
        push(3'd1, 12'h000, rb(), rb(), rb(), 4'($urandom));
        if (h) begin
            bump();
            for (int i = 0; i < 10; i++)
                push(3'd5, mk(0,0,0,0,0,0,0,0,0,0,0,1), rb(), rb(), rb(), 4'($urandom));
            return;
        end
        if (br) begin
            push(3'd2, mk(0,0,0,bt,1,0,0,0,0,imm,1,0), rb(), rb(), bt, 4'($urandom));
            bump();
            return;
        end
        push(3'd2, mk(0,0,0,0,0,0,0,0,0,imm,0,0), rb(), rb(), rb(), 4'($urandom));
        if (ld || st) begin
            for (int i = 0; i < wd; i++)
                push(3'd3, mk(0,1,0,0,0,0,ld,st,0,0,0,0), rb(), 1'b0, rb(), 4'($urandom));
            push(3'd3, mk(0,1,0,0,0,0,ld,st,0,0,0,0), rb(), 1'b1, rb(), 4'($urandom));
            if (st) begin
                bump();
                return;
            end
        end
        push(3'd4, mk(0,0,0,0,0,1,0,0,ld,0,0,0), rb(), rb(), rb(), 4'($urandom));
        bump();
    endtask

    task automatic run_trace(input int limit);
        cyc_t c;
        int   k = 0;
        while (q.size() > 0 && k < limit) begin
            c = q.pop_front();
            @(posedge clk);
            #1;
            imem_ready   = c.ir;
            dmem_ready   = c.dr;
            branch_taken = c.bt;
            opcode       = {2'($urandom), c.opc};
            @(negedge clk);
            cyc++;
            check($sformatf("c%0d_state", cyc), 32'(state), 32'(c.st));
            check($sformatf("c%0d_outs", cyc), 32'(obs_outs), 32'(c.outs));
            check($sformatf("c%0d_retired", cyc), 32'(retired), 32'(c.ret));
            k++;
        end
        q.delete();
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        #1;
        check("rst_now_state", 32'(state), 32'd0);
        check("rst_now_outs", 32'(obs_outs), 32'(mk(1,0,0,0,0,0,0,0,0,0,0,0)));
        check("rst_now_retired", 32'(retired), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_outs", 32'(obs_outs), 32'(mk(1,0,0,0,0,0,0,0,0,0,0,0)));
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = rb();
        @(negedge clk);
        check("post_rst_state", 32'(state), 32'd0);
        check("post_rst_outs", 32'(obs_outs), 32'(mk(1,0,0,0,0,0,0,0,0,0,0,0)));
        check("post_rst_retired", 32'(retired), 32'd0);
        model_ret = 0;
    endtask

    initial begin
        do_reset();

        add_instr(4'h0, 1, 0, 1'b0);
        add_instr(4'h8, 0, 3, 1'b0);
        add_instr(4'h9, 1, 0, 1'b0);
        add_instr(4'hC, 0, 0, 1'b1);
        add_instr(4'hC, 0, 0, 1'b0);
        add_instr(4'hD, 2, 0, 1'b1);
        add_instr(4'hE, 0, 0, 1'b0);
        run_trace(100000);

        for (int i = 0; i < 40; i++)
            add_instr(4'($urandom_range(0, 14)), $urandom_range(0, 2),
                      $urandom_range(0, 3), rb());
        add_instr(4'h0, 0, 0, 1'b0);
        run_trace(100000);

        add_instr(4'hF, 1, 0, 1'b0);
        run_trace(100000);

        do_reset();

        // SW stalled in MEM: reset must withdraw mem_write immediately.
        add_instr(4'h9, 0, 6, 1'b0);
        run_trace(5);
        @(posedge clk);
        #1;
        dmem_ready = 1'b0;
        check("mid_mem_write_pre", 32'(mem_write), 32'd1);
        do_reset();

        for (int i = 0; i < 8; i++)
            add_instr(4'($urandom_range(0, 14)), $urandom_range(0, 2),
                      $urandom_range(0, 3), rb());
        add_instr(4'hF, 0, 0, 1'b0);
        run_trace(100000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter OPC_W, default 4, opcode width; the opcode map occupies the low 4 bits and the upper bits are ignored.
REQ-002 Parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-003 Parameter HLT_OPC, default 4'hF, opcode that halts the machine.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 opcode  in  OPC_W  opcode field of the instruction bus; sampled only on a fetch handshake.
REQ-007 imem_ready  in  1  instruction memory has data this cycle.
REQ-008 dmem_ready  in  1  data memory access completes this cycle.
REQ-009 branch_taken  in  1  flag-condition result for the current B/BR.
REQ-010 imem_req, dmem_req  out  1 each  memory access requests.
REQ-011 ir_load, pc_write, pc_src  out  1 each  IR capture, PC update, PC source (1 = branch target).
REQ-012 reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch  out  1 each  datapath controls.
REQ-013 halted  out  1  machine stopped.
REQ-014 state  out  3  current FSM state encoding.
REQ-015 retired  out  CNT_W  count of completed instructions.

Function
REQ-016 States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; encodings 6 and 7 SHALL go to FETCH on the next edge.
REQ-017 FETCH: imem_req=1; if imem_ready=1 then ir_load=1 and pc_write=1 (PC+2) in the same cycle, opc_q<=opcode, next state DECODE; otherwise hold FETCH with no other output asserted.
REQ-018 DECODE: one cycle, no outputs asserted; next state HALT if opc_q==HLT_OPC, else EXEC.
REQ-019 EXEC: one cycle; alu_src=1 for opcodes 0100, 0101, 0110 and 1xxx; for B/BR (110x), branch=1, pc_src=1, pc_write=branch_taken, next state FETCH; for LW/SW next state MEM; all other opcodes next state WB.
REQ-020 MEM: dmem_req=1; mem_read=1 for LW (1000) and mem_write=1 for SW (1001), both held until dmem_ready=1; when dmem_ready=1, SW goes to FETCH and LW goes to WB; otherwise hold MEM.
REQ-021 WB: reg_write=1 for one cycle; mem_to_reg=1 for LW; next state FETCH.
REQ-022 reg_write SHALL assert only in WB and only for opcodes 0xxx, 1000, 1010, 1011 and 1110.
REQ-023 HALT: halted=1, every other output 0, no exit except reset; imem_ready, dmem_ready and opcode SHALL be ignored.
REQ-024 imem_ready outside FETCH, and dmem_ready outside MEM, SHALL be ignored.
REQ-025 retired SHALL increment by 1 on each transition EXEC->FETCH, MEM->FETCH, WB->FETCH and DECODE->HALT, and SHALL saturate at all-ones.
REQ-026 Outputs SHALL be combinational from state and opc_q, except ir_load, pc_write (FETCH) and pc_write (EXEC), which also depend on imem_ready and branch_taken respectively.
REQ-027 Latency with zero-wait memory: ALU/LLB/LHB/PCS 4 cycles, LW 5, SW 4, B/BR 3, HLT 2 cycles to halted=1.

Reset
REQ-028 rst_n=0 SHALL immediately force state=FETCH, opc_q=0 and retired=0, including when reset arrives mid-MEM or mid-HALT.
REQ-029 While in reset and on the first cycle after reset, imem_req=1 and every other output SHALL be 0.

Structure
REQ-030 Package wisc_ctrl_pkg SHALL hold the state encodings, named opcode constants (ADD..HLT) and the opcode-class predicate functions.
REQ-031 One combinational sub-module, opcode_class, SHALL map opc_q to the class flags is_ls, is_lw, is_br, writes_reg and uses_imm; the FSM and counter live in multicycle_ctrl.

Verification
REQ-032 ADD (0000), zero-wait memory -> states 0,1,2,4,0; reg_write high only in cycle 4; retired increments 0->1.
REQ-033 LW (1000) with dmem_ready delayed 3 cycles -> MEM held 4 cycles with mem_read=1 and dmem_req=1 throughout; WB has mem_to_reg=1; total 8 cycles.
REQ-034 B (1100) with branch_taken=1, then with branch_taken=0 -> EXEC shows pc_src=1 and pc_write=1, then pc_write=0; no WB state visited in either case.
REQ-035 HLT (1111) -> halted=1 on cycle 3; retired increments once; imem_ready toggling for 10 cycles -> no change to any output.
REQ-036 rst_n pulsed low mid-MEM of an SW -> mem_write drops in the same cycle; after release, state=0, retired=0, imem_req=1.
REQ-037 Preload retired to all-ones by running 2^CNT_W-1 instructions with CNT_W=4, then run one more ADD -> retired stays 4'hF.
